sr_frame_sequencer: RTL

Sequences the 8-bit output shift register (load / ready handshake) to send a multi-byte frame (display segment or digit data), then pulses a latch strobe for the external 74HC595-style register chain. Frames start on an explicit request or from an internal refresh timer. The block sits between the clock/display logic that produces frame data and the shift-register block that drives the serial pins.

---
 rtl/sr_frame_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sr_frame_sequencer.sv
// Frame sequencer: feeds a multi-byte frame, most significant byte first, into an 8-bit
// load/ready shift register and then pulses the latch strobe of an external 74HC595 chain.
module sr_frame_sequencer #(
  parameter int NUM_BYTES      = 2,
  parameter int LATCH_CYCLES   = 2,
  parameter int REFRESH_PERIOD = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [8*NUM_BYTES-1:0] i_frame,
  output logic                   o_sr_load,
  output logic [7:0]             o_sr_data,
  input  logic                   i_sr_rdy,
  output logic                   o_latch,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_pending,
  output logic [2:0]             o_state
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(NUM_BYTES - 1);
  localparam logic [3:0]       LAT_LAST  = 4'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SKIP  = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4,
    S_LATCH = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_BYTES-1:0][7:0]   frame_q, frame_d;
  logic [3:0]                  lat_cnt_q, lat_cnt_d;
  logic                        pend_q, pend_d;
  logic                        tick;
  logic                        busy;
  logic                        req;

  // Refresh timer: one-cycle tick on count REFRESH_PERIOD-1, then wrap.
  if (REFRESH_PERIOD > 0) begin : g_refresh
    localparam logic [23:0] REF_LAST = 24'(REFRESH_PERIOD - 1);
    logic [23:0] ref_cnt_q;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        ref_cnt_q <= 24'd0;
      end else if (ref_cnt_q == REF_LAST) begin
        ref_cnt_q <= 24'd0;
      end else begin
        ref_cnt_q <= ref_cnt_q + 24'd1;
      end
    end

    assign tick = (ref_cnt_q == REF_LAST);
  end else begin : g_no_refresh
    assign tick = 1'b0;
  end

  assign busy = (state_q != S_IDLE);
  assign req  = i_start | tick | pend_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      frame_q   <= '0;
      lat_cnt_q <= 4'd0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      lat_cnt_q <= lat_cnt_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    lat_cnt_d = lat_cnt_q;
    pend_d    = pend_q;

    // Requests arriving mid-frame collapse into a single queued frame.
    if (busy && (i_start || tick)) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (req) begin
          frame_d = i_frame;
          pend_d  = 1'b0;
          idx_d   = IDX_FIRST;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (i_sr_rdy) begin
          state_d = S_SKIP;
        end
      end
      S_SKIP: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_sr_rdy) begin
          if (idx_q != '0) begin
            idx_d   = idx_q - 1'b1;
            state_d = S_LOAD;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        lat_cnt_d = 4'd0;
        state_d   = S_LATCH;
      end
      S_LATCH: begin
        if (lat_cnt_q == LAT_LAST) begin
          state_d = S_DONE;
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_sr_load = (state_q == S_LOAD) && i_sr_rdy;
  assign o_sr_data = busy ? frame_q[idx_q] : 8'h00;
  assign o_latch   = (state_q == S_LATCH);
  assign o_busy    = busy;
  assign o_done    = (state_q == S_DONE);
  assign o_pending = pend_q;
  assign o_state   = state_q;

endmodule
